fm_audio_decim_fir: RTL and testbench
=====================================

# fm_audio_decim_fir

Decimating FIR low-pass stage for the FM audio path. It consumes demodulated baseband samples at the full sample rate and keeps a 32-deep sample history. It produces one filtered, dequantized audio sample for every 8 accepted inputs, which feeds the de-emphasis IIR and volume stages. It uses the package quantization: fixed point with 10 fraction bits, scale 1024.

## Interface
Parameters:
- DATA_WIDTH, 32, signed sample and coefficient width.
- TAPS, 32, filter length; matches MAX_TAPS.
- DECIM, 8, decimation factor; matches the audio decimation constant.
- BITS, 10, fraction bits removed after accumulation.

Ports:
- clock, in, 1, single clock; all logic is rising-edge.
- reset_n, in, 1, asynchronous active-low reset.
- in_data, in, DATA_WIDTH, signed quantized input sample.
- in_valid, in, 1, input sample present.
- in_ready, out, 1, block can accept a sample this cycle.
- out_data, out, DATA_WIDTH, signed filtered audio sample.
- out_valid, out, 1, out_data valid.
- out_ready, in, 1, downstream accepts out_data.
- coeff_we, in, 1, coefficient write strobe.
- coeff_addr, in, 5, tap index k (0..TAPS-1).
- coeff_data, in, DATA_WIDTH, signed quantized coefficient h[k].

## Operation
- Transfer rule: a transfer happens when valid && ready are both high on a rising edge. This applies on both sides.
- Storage:
  - History: circular buffer x[0..31] with write pointer wp (5 bits, wraps 31→0).
  - Coefficients: h[0..31].
  - Decimation counter dc (0..7).
  - Signed accumulator acc, 64 bits.
  - Tap counter tc (0..31).
- FILL state (in_ready=1, out_valid=0):
  - Each accepted sample is written to x[wp]; wp increments.
  - dc increments on each accepted sample.
  - When the 8th sample is accepted (dc==7): dc←0, acc←0, tc←0, go to MAC.
- MAC state (in_ready=0):
  - One tap per cycle: acc += h[tc] * x[wp-1-tc] (mod 32). x[wp-1] is the newest sample, so y = Σ h[k]·x[n−k].
  - Each product is the full 64-bit signed result.
  - After tc==31 is accumulated, go to OUT.
- OUT state:
  - out_valid=1.
  - out_data = acc / 1024, truncated toward zero (matches the integer DEQUANTIZE_I; not an arithmetic shift). Then truncated to the low 32 bits.
  - out_data is held stable until out_ready; on transfer, go to FILL.
- Coefficient writes:
  - coeff_we writes h[coeff_addr] in FILL and OUT.
  - coeff_we is ignored (write dropped) during MAC.
- Overflow: acc wraps at 64 bits; no saturation.
- Reset (asserted at any time, including mid-MAC or mid-OUT):
  - State→FILL; wp, dc, tc, acc → 0.
  - All x[] and all h[] → 0.
  - in_ready=1 and out_valid=0, with out_data=0, immediately on assertion.
  - A partially computed output is discarded.

## Timing
- in_ready is 1 in FILL only; it is low for exactly 32+1+N cycles per output. N is the number of out_ready stall cycles.
- Latency: the 8th sample is accepted at edge t. MAC occupies edges t+1..t+32. out_valid rises after edge t+32 and is visible in cycle t+33.
- With out_ready held high, the output transfers at edge t+33 and in_ready is 1 again in cycle t+34.
- Maximum throughput: one output per 8+33 = 41 cycles.
- out_valid must not drop and out_data must not change while out_ready=0.
- in_valid in MAC/OUT is ignored; the sample is not consumed.
- Coefficient write timing:
  - A write at edge e during FILL or OUT is used by any MAC that begins after e.
  - A write in the same cycle as the FILL→MAC transition (edge t) is accepted.

## Test plan
- Identity: h[0]=1024, rest 0. Feed samples 1024·i for i=1..16 → outputs 8192, then 16384. in_ready is low 33 cycles after each 8th sample.
- Moving sum: all h=1024. Feed 40 samples each of value 2048 → first output 16384 (8 nonzero history), then 32768, 49152, 65536, 65536.
- Negative rounding: h[0]=1, rest 0. Input −1025 as the 8th sample → out_data=−1 (truncation toward zero, not −2).
- Backpressure: hold out_ready=0 for 20 cycles in OUT → out_valid and out_data are stable, in_ready=0 throughout. Release → one transfer, then FILL.
- Dropped coefficient write: pulse coeff_we during MAC with h[0]=5120 → this output and the next are unchanged. The same write in FILL takes effect on the next output.
- Reset mid-MAC: assert reset_n=0 at MAC cycle 10 → out_valid=0 and in_ready=1 asynchronously. After release, 8 samples of 1024 with h reloaded (h[0]=1024) → output 1024; old history contributes zero.

Source files
------------

// File: rtl/fm_audio_decim_fir_if.sv
// Sample stream (in/out handshakes) and coefficient write port for the
// FM audio decimating FIR stage.
interface fm_audio_decim_fir_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic                         coeff_we;
  logic [ADDR_WIDTH-1:0]        coeff_addr;
  logic signed [DATA_WIDTH-1:0] coeff_data;

  // Upstream/control side: produces samples and coefficients, consumes audio.
  modport master (
    output in_data, in_valid, out_ready, coeff_we, coeff_addr, coeff_data,
    input  in_ready, out_data, out_valid
  );

  // Filter side.
  modport slave (
    input  in_data, in_valid, out_ready, coeff_we, coeff_addr, coeff_data,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/fm_audio_decim_fir.sv
// Decimating FIR low-pass for the FM audio path: keeps a TAPS-deep circular
// sample history, and after every DECIM accepted samples runs one serial MAC
// pass (one tap per cycle) and presents acc/2^BITS truncated toward zero.
module fm_audio_decim_fir #(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 32,
  parameter int DECIM      = 8,
  parameter int BITS       = 10
) (
  input  logic               clock,
  input  logic               reset_n,
  fm_audio_decim_fir_if.slave bus
);
  localparam int AW    = $clog2(TAPS);
  localparam int DCW   = $clog2(DECIM);
  localparam int ACC_W = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_FILL,
    S_MAC,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  logic signed [DATA_WIDTH-1:0] x_q [TAPS];
  logic signed [DATA_WIDTH-1:0] h_q [TAPS];
  logic [AW-1:0]                wp_q;
  logic [AW-1:0]                tc_q;
  logic [AW-1:0]                x_idx;
  logic [DCW-1:0]               dc_q;
  logic signed [ACC_W-1:0]      acc_q;
  logic signed [ACC_W-1:0]      prod;
  logic signed [ACC_W-1:0]      acc_sum;
  logic signed [ACC_W-1:0]      acc_biased;
  logic signed [DATA_WIDTH-1:0] out_q;
  logic                         in_fire;
  logic                         dc_last;
  logic                         tc_last;
  logic                         mac_start;
  logic                         unused_acc_bits;

  // Handshake outputs decode straight from the state register so reset
  // forces in_ready=1 / out_valid=0 without waiting for a clock.
  assign bus.in_ready  = (state_q == S_FILL);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_data  = out_q;

  assign in_fire   = bus.in_valid && (state_q == S_FILL);
  assign dc_last   = (dc_q == DCW'(DECIM - 1));
  assign tc_last   = (tc_q == AW'(TAPS - 1));
  assign mac_start = in_fire && dc_last;

  // wp-1 is the newest sample, so tap k reads x[wp-1-k] (wraps mod TAPS).
  assign x_idx   = wp_q - AW'(1) - tc_q;
  assign prod    = ACC_W'(h_q[tc_q]) * ACC_W'(x_q[x_idx]);
  assign acc_sum = acc_q + prod;

  // Divide by 2^BITS toward zero: negative sums get (2^BITS - 1) added before
  // the shift, so -1025/1024 gives -1 rather than the floor value -2.
  assign acc_biased = acc_sum + (acc_sum[ACC_W-1] ? ACC_W'((1 << BITS) - 1) : '0);
  assign unused_acc_bits = ^{acc_biased[ACC_W-1:BITS+DATA_WIDTH], acc_biased[BITS-1:0]};

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: fill DECIM samples, one MAC pass over all taps, hold output.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:  if (mac_start) state_d = S_MAC;
      S_MAC:   if (tc_last) state_d = S_OUT;
      S_OUT:   if (bus.out_ready) state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  // Sample history write and decimation count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
      end
      wp_q <= '0;
      dc_q <= '0;
    end else if (in_fire) begin
      x_q[wp_q] <= bus.in_data;
      wp_q      <= wp_q + AW'(1);
      dc_q      <= dc_last ? '0 : dc_q + DCW'(1);
    end
  end

  // Coefficient writes; dropped while a MAC pass is reading them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        h_q[i] <= '0;
      end
    end else if (bus.coeff_we && (state_q != S_MAC)) begin
      h_q[bus.coeff_addr] <= bus.coeff_data;
    end
  end

  // Serial MAC and output register; the final tap is folded directly into
  // the dequantized output so out_data is ready when OUT is entered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      tc_q  <= '0;
      out_q <= '0;
    end else if (mac_start) begin
      acc_q <= '0;
      tc_q  <= '0;
    end else if (state_q == S_MAC) begin
      acc_q <= acc_sum;
      tc_q  <= tc_q + AW'(1);
      if (tc_last) begin
        out_q <= acc_biased[BITS +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_fm_audio_decim_fir.sv
// Self-checking bench for fm_audio_decim_fir: a sample-level reference model
// (history queue, coefficient array, 64-bit sum, integer division) is
// compared against the DUT every cycle, plus directed literal checks.
module tb_fm_audio_decim_fir;
  localparam int DW = 32;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  fm_audio_decim_fir_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(5)) bus ();

  fm_audio_decim_fir #(
    .DATA_WIDTH(DW),
    .TAPS(32),
    .DECIM(8),
    .BITS(10)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  typedef enum {M_FILL, M_MAC, M_OUT} mphase_t;

  mphase_t m_phase    = M_FILL;
  int      m_cnt      = 0;
  int      m_mac_left = 0;
  int      m_exp      = 0;
  int      hist[$];
  int      coef[32];
  int      exp_q[$];
  int      got_q[$];
  int      tests = 0;
  int      fails = 0;

  task automatic check(string name, longint act, longint want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // y = sum_k h[k] * x[n-k], wrapped at 64 bits, divided toward zero by 1024.
  function automatic int filter_out();
    longint s = 0;
    for (int k = 0; k < 32; k++) begin
      s += longint'(coef[k]) * longint'(hist[k]);
    end
    return int'(s / 64'sd1024);
  endfunction

  // Reference model: hist[0] is always the newest sample.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_phase    = M_FILL;
      m_cnt      = 0;
      m_mac_left = 0;
      m_exp      = 0;
      hist.delete();
      for (int i = 0; i < 32; i++) begin
        hist.push_back(0);
        coef[i] = 0;
      end
    end else begin
      if (bus.coeff_we && m_phase != M_MAC) coef[bus.coeff_addr] = bus.coeff_data;
      case (m_phase)
        M_FILL: if (bus.in_valid) begin
          hist.push_front(bus.in_data);
          void'(hist.pop_back());
          m_cnt++;
          if (m_cnt == 8) begin
            m_cnt      = 0;
            m_exp      = filter_out();
            m_phase    = M_MAC;
            m_mac_left = 32;
          end
        end
        M_MAC: begin
          m_mac_left--;
          if (m_mac_left == 0) m_phase = M_OUT;
        end
        M_OUT: if (bus.out_ready) begin
          exp_q.push_back(m_exp);
          got_q.push_back(bus.out_data);
          m_phase = M_FILL;
        end
        default: m_phase = M_FILL;
      endcase
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clock) begin
    check("in_ready", bus.in_ready, (m_phase == M_FILL) ? 1 : 0);
    check("out_valid", bus.out_valid, (m_phase == M_OUT) ? 1 : 0);
    if (!reset_n) check("reset_out_data", bus.out_data, 0);
    else if (m_phase == M_OUT) check("out_data", bus.out_data, m_exp);
  end

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.coeff_we   = 1'b0;
    bus.coeff_addr = '0;
    bus.coeff_data = '0;
    bus.out_ready  = 1'b1;
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
  endtask

  // Entered just after a negedge; returns at the negedge after acceptance.
  task automatic send(int v);
    int n = 0;
    bus.in_data  = v;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (!bus.in_ready) check("send_timeout", bus.in_ready, 1);
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic load_coef(int k, int v);
    bus.coeff_we   = 1'b1;
    bus.coeff_addr = 5'(k);
    bus.coeff_data = v;
    @(negedge clock);
    bus.coeff_we   = 1'b0;
  endtask

  task automatic wait_outputs(int n);
    int c = 0;
    while (exp_q.size() < n && c < 2000) begin
      @(negedge clock);
      c++;
    end
    if (exp_q.size() < n) check("wait_out_timeout", exp_q.size(), n);
  endtask

  task automatic check_out(string name, int idx, int want);
    if (idx < exp_q.size()) begin
      check({name, "_model"}, exp_q[idx], want);
      check({name, "_dut"}, got_q[idx], want);
    end else begin
      check({name, "_missing"}, exp_q.size(), idx + 1);
    end
  endtask

  function automatic int rand_val();
    if ($urandom_range(0, 3) == 0) return int'($urandom);
    return int'($urandom_range(0, 8000)) - 4000;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got no summary expected one");
    $fatal(1);
  end

  initial begin
    int n;
    idle_inputs();
    repeat (3) @(negedge clock);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    #2 reset_n = 1'b1;
    @(negedge clock);

    // Identity filter: 33 busy cycles after each 8th sample.
    clear_q();
    load_coef(0, 1024);
    for (int i = 1; i <= 16; i++) begin
      send(1024 * i);
      if (i % 8 == 0) begin
        n = 0;
        while (!bus.in_ready && n < 100) begin
          n++;
          @(negedge clock);
        end
        check("id_busy_cycles", n, 33);
      end
    end
    check_out("id0", 0, 8192);
    check_out("id1", 1, 16384);

    // Moving sum over all 32 taps.
    do_reset();
    clear_q();
    for (int k = 0; k < 32; k++) load_coef(k, 1024);
    for (int i = 0; i < 40; i++) send(2048);
    wait_outputs(5);
    check_out("ms0", 0, 16384);
    check_out("ms1", 1, 32768);
    check_out("ms2", 2, 49152);
    check_out("ms3", 3, 65536);
    check_out("ms4", 4, 65536);

    // Negative value truncates toward zero.
    do_reset();
    clear_q();
    load_coef(0, 1);
    for (int i = 0; i < 7; i++) send(0);
    send(-1025);
    wait_outputs(1);
    check_out("neg", 0, -1);

    // Backpressure: output held while out_ready is low.
    do_reset();
    clear_q();
    load_coef(0, 1024);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(3072);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("bp_latency", n, 32);
    repeat (20) begin
      @(negedge clock);
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_data", bus.out_data, 3072);
      check("bp_hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    check("bp_release_in_ready", bus.in_ready, 1);
    check("bp_release_out_valid", bus.out_valid, 0);
    check_out("bp", 0, 3072);
    check("bp_single_transfer", exp_q.size(), 1);

    // Coefficient write during MAC is dropped; in FILL it takes effect.
    do_reset();
    clear_q();
    load_coef(0, 1024);
    for (int i = 0; i < 8; i++) send(1024);
    load_coef(0, 5120);
    wait_outputs(1);
    for (int i = 0; i < 8; i++) send(1024);
    wait_outputs(2);
    load_coef(0, 5120);
    for (int i = 0; i < 8; i++) send(1024);
    wait_outputs(3);
    check_out("cw0", 0, 1024);
    check_out("cw1", 1, 1024);
    check_out("cw2", 2, 5120);

    // Reset in the middle of a MAC pass.
    do_reset();
    clear_q();
    load_coef(0, 1024);
    for (int i = 0; i < 8; i++) send(7000);
    repeat (9) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("rr_in_ready", bus.in_ready, 1);
    check("rr_out_valid", bus.out_valid, 0);
    check("rr_out_data", bus.out_data, 0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    load_coef(0, 1024);
    for (int i = 0; i < 8; i++) send(1024);
    wait_outputs(1);
    check_out("rr", 0, 1024);
    check("rr_single_output", exp_q.size(), 1);

    // Randomized traffic against the model.
    do_reset();
    clear_q();
    for (int k = 0; k < 32; k++) load_coef(k, rand_val());
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      bus.in_valid   = 1'($urandom_range(0, 1));
      bus.in_data    = rand_val();
      bus.coeff_we   = ($urandom_range(0, 7) == 0);
      bus.coeff_addr = 5'($urandom_range(0, 31));
      bus.coeff_data = rand_val();
      bus.out_ready  = ($urandom_range(0, 3) != 0);
    end
    @(negedge clock);
    idle_inputs();
    repeat (60) @(negedge clock);
    check("rand_outputs_seen", (exp_q.size() > 20) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
